// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter command sequencer.
// Holds the sequencer FSM state type, the direction encodings and the
// default widths of the counter value and the per-command step count.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEF_COUNT_W = 8;
    localparam int unsigned DEF_STEP_W  = 4;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin grant.
// Ports:
//   req_i  in  2  request vector
//   ptr_i  in  1  index of the requester that currently has priority
//   gnt_o  out 2  one-hot grant, all zero when nothing requests
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_i]) begin
            gnt_o[ptr_i] = 1'b1;
        end else if (req_i[~ptr_i]) begin
            gnt_o[~ptr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Shares one up/down/hold counter between two requesters. Each requester
// submits "step N times up/down"; a round-robin arbiter picks one command,
// then the FSM drives the counter hold/up controls for N edges, stopping
// early when the fed-back counter value sits on the bound for the direction.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               block enable; low freezes the FSM and holds the counter
//   req_valid/ready   per-requester handshake (2 bits each)
//   req_dir           per-requester direction, 1 = up
//   req_steps         per-requester step count, requester i at [i*STEP_W +: STEP_W]
//   cnt_value         live counter value (bound detection)
//   cnt_hold, cnt_up  counter controls
//   busy              command in flight
//   done, done_id, sat  one-cycle completion pulse, requester index, cut-short flag
module counter_cmd_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned       COUNT_W = DEF_COUNT_W,
    parameter int unsigned       STEP_W  = DEF_STEP_W,
    parameter logic [COUNT_W-1:0] CNT_MAX = '1,
    parameter logic [COUNT_W-1:0] CNT_MIN = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_dir,
    input  logic [2*STEP_W-1:0] req_steps,
    output logic [1:0]          req_ready,
    input  logic [COUNT_W-1:0]  cnt_value,
    output logic                cnt_hold,
    output logic                cnt_up,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic                sat
);

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                id_q, id_d;
    logic                sat_q, sat_d;

    logic [1:0]          gnt;
    logic                gnt_id;
    logic [STEP_W-1:0]   steps_sel;
    logic                at_bound;

    rr_arbiter_2 u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    assign gnt_id    = gnt[1];
    assign steps_sel = gnt_id ? req_steps[STEP_W +: STEP_W] : req_steps[0 +: STEP_W];
    assign at_bound  = ((dir_q == DIR_UP) && (cnt_value == CNT_MAX)) ||
                       ((dir_q == DIR_DOWN) && (cnt_value == CNT_MIN));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        id_d      = id_q;
        sat_d     = sat_q;
        req_ready = 2'b00;
        cnt_hold  = 1'b1;
        cnt_up    = 1'b0;
        done      = 1'b0;
        done_id   = 1'b0;
        sat       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ena) begin
                    // gnt is nonzero only when some requester is valid, so a
                    // nonzero grant is itself the transfer condition.
                    req_ready = gnt;
                    if (gnt != 2'b00) begin
                        dir_d   = req_dir[gnt_id];
                        rem_d   = steps_sel;
                        id_d    = gnt_id;
                        sat_d   = 1'b0;
                        state_d = (steps_sel != '0) ? RUN : DONE;
                    end
                end
            end
            RUN: begin
                cnt_up = dir_q;
                if (ena) begin
                    cnt_hold = at_bound;
                    if (at_bound) begin
                        sat_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // rem is never zero in RUN, so this cannot wrap.
                        rem_d = rem_q - STEP_W'(1);
                        if (rem_q == STEP_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (ena) begin
                    done     = 1'b1;
                    done_id  = id_q;
                    sat      = sat_q;
                    rr_ptr_d = ~id_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            id_q     <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            id_q     <= id_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] req_valid;
    logic [1:0] req_dir;
    logic [7:0] req_steps;
    logic [1:0] req_ready;
    logic [7:0] cnt_value;
    logic       cnt_hold;
    logic       cnt_up;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       sat;

    // Counter datapath model driven by the DUT controls.
    logic [7:0] cnt_q;
    logic       cnt_load;
    logic [7:0] cnt_load_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_load_val;
        else if (!cnt_hold) cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end
    assign cnt_value = cnt_q;

    counter_cmd_sequencer #(
        .COUNT_W (8),
        .STEP_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_steps (req_steps),
        .req_ready (req_ready),
        .cnt_value (cnt_value),
        .cnt_hold  (cnt_hold),
        .cnt_up    (cnt_up),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .sat       (sat)
    );

    typedef struct {
        int   rq;
        logic dir;
        int   steps;
        int   start;
        int   exp_steps;
        int   exp_lat;
        int   exp_final;
        int   exp_sat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cnt(input int v);
        cnt_load     = 1'b1;
        cnt_load_val = v[7:0];
        next_cycle();
        cnt_load     = 1'b0;
    endtask

    // Issue one command from requester rq and follow it to its done pulse.
    task automatic run_cmd(input int rq, input logic dir, input int steps,
                           output int nsteps, output int lat, output int d_id,
                           output int d_sat);
        logic [3:0] s;
        s         = steps[3:0];
        req_valid = (rq == 0) ? 2'b01 : 2'b10;
        req_dir   = {dir, dir};
        req_steps = {s, s};
        #1;
        chk("grant", int'(req_ready), (rq == 0) ? 1 : 2);
        next_cycle();
        req_valid = 2'b00;
        #1;
        nsteps = 0;
        lat    = -1;
        d_id   = -1;
        d_sat  = -1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                lat   = c;
                d_id  = int'(done_id);
                d_sat = int'(sat);
                break;
            end
            if (!cnt_hold) nsteps++;
            next_cycle();
            #1;
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int nsteps, lat, d_id, d_sat, ndone, raised, gap_steps;
        int got[4];
        logic [1:0] acc;

        vecs[0] = '{0, 1'b1, 5,  10,  5,  5,  15,  0};
        vecs[1] = '{1, 1'b1, 5,  253, 2,  3,  255, 1};
        vecs[2] = '{0, 1'b0, 3,  1,   1,  2,  0,   1};
        vecs[3] = '{0, 1'b1, 0,  7,   0,  0,  7,   0};
        vecs[4] = '{1, 1'b0, 15, 100, 15, 15, 85,  0};
        vecs[5] = '{1, 1'b1, 1,  254, 1,  1,  255, 0};
        vecs[6] = '{0, 1'b1, 3,  255, 0,  1,  255, 1};

        rst          = 1'b1;
        ena          = 1'b1;
        req_valid    = 2'b00;
        req_dir      = 2'b00;
        req_steps    = 8'h00;
        cnt_load     = 1'b0;
        cnt_load_val = 8'h00;
        #2;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_hold", int'(cnt_hold), 1);
        chk("rst_up", int'(cnt_up), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_sat", int'(sat), 0);
        load_cnt(0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Contention: both requesters valid right after reset, twice over.
        req_dir   = 2'b11;
        req_steps = {4'd2, 4'd2};
        req_valid = 2'b11;
        #1;
        chk("cont_first_grant", int'(req_ready), 1);
        ndone  = 0;
        raised = 0;
        for (int c = 0; c < 80 && ndone < 4; c++) begin
            if (c > 0) #1;
            if (done) begin
                got[ndone] = int'(done_id);
                ndone++;
                if (ndone == 4) break;
            end
            acc = req_valid & req_ready;
            next_cycle();
            req_valid = req_valid & ~acc;
            if (req_valid == 2'b00 && raised == 0) begin
                raised    = 1;
                req_valid = 2'b11;
            end
        end
        chk("cont_ndone", ndone, 4);
        for (int i = 0; i < 4; i++) chk("cont_done_id", got[i], i % 2);
        chk("cont_final_cnt", int'(cnt_q), 8);
        req_valid = 2'b00;
        next_cycle();

        // Table-driven single commands.
        for (int i = 0; i < 7; i++) begin
            load_cnt(vecs[i].start);
            run_cmd(vecs[i].rq, vecs[i].dir, vecs[i].steps, nsteps, lat, d_id, d_sat);
            chk("vec_steps", nsteps, vecs[i].exp_steps);
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_final_cnt", int'(cnt_q), vecs[i].exp_final);
            chk("vec_done_id", d_id, vecs[i].rq);
            chk("vec_sat", d_sat, vecs[i].exp_sat);
            next_cycle();
            chk("vec_idle_busy", int'(busy), 0);
            chk("vec_idle_done", int'(done), 0);
        end

        // Reset in the middle of an 8-step up command.
        load_cnt(50);
        req_valid = 2'b01;
        req_dir   = 2'b01;
        req_steps = {4'd0, 4'd8};
        #1;
        next_cycle();
        req_valid = 2'b00;
        for (int c = 0; c < 3; c++) next_cycle();
        chk("mid_busy", int'(busy), 1);
        chk("mid_hold", int'(cnt_hold), 0);
        rst = 1'b1;
        #1;
        chk("abort_hold", int'(cnt_hold), 1);
        chk("abort_up", int'(cnt_up), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(req_ready), 0);
        chk("abort_cnt", int'(cnt_q), 53);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            chk("abort_no_done", int'(done), 0);
        end
        chk("abort_cnt_held", int'(cnt_q), 53);
        rst = 1'b0;
        next_cycle();

        // ena gating: idle refusal, then a 4-cycle gap inside RUN.
        load_cnt(20);
        ena       = 1'b0;
        req_valid = 2'b01;
        req_dir   = 2'b01;
        req_steps = {4'd0, 4'd6};
        #1;
        chk("ena_idle_ready", int'(req_ready), 0);
        next_cycle();
        chk("ena_idle_busy", int'(busy), 0);
        ena = 1'b1;
        #1;
        chk("ena_grant", int'(req_ready), 1);
        next_cycle();
        req_valid = 2'b00;
        nsteps    = 0;
        gap_steps = 0;
        lat       = -1;
        for (int c = 0; c < 60; c++) begin
            ena = (c >= 2 && c < 6) ? 1'b0 : 1'b1;
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (!cnt_hold) nsteps++;
            if (!ena && !cnt_hold) gap_steps++;
            next_cycle();
        end
        chk("gap_steps", gap_steps, 0);
        chk("gap_total_steps", nsteps, 6);
        chk("gap_latency", lat, 10);
        chk("gap_final_cnt", int'(cnt_q), 26);
        ena = 1'b1;
        next_cycle();

        // ena low across the DONE cycle delays the pulse.
        load_cnt(0);
        req_valid = 2'b10;
        req_dir   = 2'b10;
        req_steps = {4'd1, 4'd0};
        #1;
        chk("dly_grant", int'(req_ready), 2);
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        ena = 1'b0;
        #1;
        chk("dly_done_suppressed", int'(done), 0);
        next_cycle();
        chk("dly_done_still_low", int'(done), 0);
        chk("dly_busy", int'(busy), 1);
        ena = 1'b1;
        #1;
        chk("dly_done", int'(done), 1);
        chk("dly_done_id", int'(done_id), 1);
        chk("dly_cnt", int'(cnt_q), 1);
        next_cycle();
        chk("dly_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Shares the up/down/hold counter datapath between two requesters.
- Each requester submits a "step N times up/down" command over a valid/ready handshake.
- A round-robin arbiter picks one command at a time. An FSM then drives the counter's hold/up controls for exactly N clock edges, stopping early if the counter reaches its bound.
- Sits between the requester logic and the counter in the same tile; the counter's live value feeds back for bound detection.

Parameters:
- COUNT_W, 8: width of the counter value fed back.
- STEP_W, 4: width of each requester's step-count field (max 15 steps per command).
- CNT_MAX, 2**COUNT_W-1: upper bound; an up-step is never issued while cnt_value == CNT_MAX.
- CNT_MIN, 0: lower bound; a down-step is never issued while cnt_value == CNT_MIN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  block enable; low freezes the FSM.
- req_valid  in  2  per-requester command valid.
- req_dir  in  2  per-requester direction: 1 = up, 0 = down.
- req_steps  in  2*STEP_W  per-requester step count; requester i uses bits [i*STEP_W +: STEP_W].
- req_ready  out  2  per-requester accept; a transfer happens on a clock edge where valid&ready are both high.
- cnt_value  in  COUNT_W  current counter value.
- cnt_hold  out  1  counter hold control; 1 = counter holds.
- cnt_up  out  1  counter direction control; 1 = increment, 0 = decrement.
- busy  out  1  high while a command is in flight, i.e. not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  index of the requester whose command completed; valid with done.
- sat  out  1  command was cut short by a bound; valid with done.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; rr_ptr=0, meaning requester 0 has priority.
  - Outputs: req_ready=00, cnt_hold=1, cnt_up=0, busy=0, done=0, done_id=0, sat=0.
  - Latched dir, steps and id are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: a one-hot grant only when ena=1 and at least one req_valid is high.
  - Grant goes to rr_ptr's requester if it is valid, otherwise to the other requester.
  - On a transfer edge: latch dir, steps into rem, and id.
  - Next state is RUN if steps != 0; if steps == 0 go straight to DONE with sat=0.
- RUN:
  - at_bound = (dir=1 and cnt_value==CNT_MAX) or (dir=0 and cnt_value==CNT_MIN).
  - cnt_hold = at_bound (combinational); cnt_up = dir.
  - Each edge with !at_bound steps the counter once and decrements rem.
  - rem==1 with !at_bound: this is the last step; go to DONE with sat=0.
  - at_bound: no step is issued; go to DONE with sat=1.
- DONE:
  - Lasts one cycle: done=1, done_id=id, sat as latched, cnt_hold=1.
  - rr_ptr becomes !id.
  - Next state is IDLE.
- Outside RUN: cnt_hold=1 and cnt_up=0.
- Latency:
  - Accept edge, then N RUN cycles (N counter edges), then 1 DONE cycle, then IDLE.
  - Minimum spacing between accepts is N+2 cycles.
- ena=0:
  - State, rem and rr_ptr hold.
  - cnt_hold=1 and req_ready=00.
  - done is suppressed and reasserts for one cycle when ena returns high.
- Handshake rules:
  - A requester may drop valid before ready with no side effect.
  - req_dir and req_steps must be stable while valid is high.
  - The non-granted requester sees ready=0 and keeps waiting.
- Simultaneous valid from both requesters: rr_ptr decides, so back-to-back contention alternates 0,1,0,1.
- Reset mid-RUN: the command is aborted immediately and no done is produced. The counter is left at its current value; the requester must resubmit.
- Arithmetic: rem is STEP_W bits, decrements only while in RUN, and never wraps.

Decomposition:
- Shared package counter_ctrl_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - DIR_UP=1 and DIR_DOWN=0 constants;
  - default COUNT_W and STEP_W.
- One sub-module, rr_arbiter_2: 2-input round-robin grant with a pointer input and a one-hot grant output.

Test Plan:
- Up 5: cnt_value=10, req0 valid dir=1 steps=5 → ready0 for 1 cycle; cnt_hold=0/cnt_up=1 for exactly 5 cycles; counter=15; done=1, done_id=0, sat=0.
- Contention: both valid with steps=2 right after reset → req0 served first, then req1. A second simultaneous pair is served 0 then 1; done_id sequence is 0,1,0,1.
- Saturation: cnt_value=253, req1 up steps=5 → 2 steps; counter=255; cnt_hold=1 in the third RUN cycle; done with sat=1, done_id=1. A mirror case, down from 1 with steps=3, gives counter=0 and sat=1.
- Zero steps: req0 steps=0 → accept, then DONE next cycle; cnt_hold never low; sat=0.
- Reset mid-RUN: assert rst after 3 of 8 steps → all outputs return to reset values asynchronously; no done; counter=start+3.
- ena gating: drop ena for 4 cycles mid-RUN → no steps during the gap; total steps still equals N; done is delayed by 4 cycles.
